// File: rtl/periph_link_pkg.sv
// Shared definitions for the CPU-to-peripheral send/ack nibble link.
// Used by the receive stage here and by the CPU-side sender FSM.
package periph_link_pkg;

  localparam int LINK_DATA_W = 4;

  typedef enum logic {
    IDLE,
    ACK
  } rx_state_t;

endpackage

// File: rtl/periph_rx_fifo_sync_fifo.sv
// Single-clock circular FIFO with occupancy count.
// The head word reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/periph_rx_fifo.sv
// Receive stage of the send/ack link: synchronises send, acks words
// into a FIFO, and withholds ack while the FIFO is full.
module periph_rx_fifo
  import periph_link_pkg::*;
#(
  parameter int DATA_W      = LINK_DATA_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send,
  input  logic [DATA_W-1:0]          data,
  output logic                       ack,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   send_s;
  rx_state_t              state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   push;
  logic                   fifo_empty;
  logic                   fifo_full;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], send};
  assign send_s = sync_q[SYNC_STAGES-1];

  // data is only sampled once send_s is high, when the sender holds it.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (send_s && !fifo_full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d = 1'b1;
        if (!send_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  assign ack       = ack_q;
  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_periph_rx_fifo.sv
// Scoreboard bench for periph_rx_fifo: words are queued when offered
// by the sender model and checked as the consumer pops them.
module tb_periph_rx_fifo;

  logic       clk;
  logic       sclk;
  logic       rst;
  logic       send;
  logic [3:0] data;
  logic       ack;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  periph_rx_fifo #(
    .DATA_W      (4),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .data      (data),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial sclk = 1'b0;
  always #16 sclk = ~sclk;

  task automatic wait_ack(input logic val, input string name);
    int n = 0;
    while (ack !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (ack !== val) begin
      fails++;
      $display("FAIL %s: ack=%b required %b", name, ack, val);
    end
  endtask

  task automatic pop_one(input string name);
    int n = 0;
    logic [3:0] exp;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bx;
    tests++;
    if (!out_valid || out_data !== exp) begin
      fails++;
      $display("FAIL %s: out_valid=%b out_data=%h required %h",
               name, out_valid, out_data, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic xfer(input logic [3:0] d);
    data = d;
    send = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1, "xfer_ack_hi");
    send = 1'b0;
    wait_ack(1'b0, "xfer_ack_lo");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send = 1'b1;
    data = 4'h7;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (ack !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0
          || out_data !== 4'h0) begin
        fails++;
        $display("FAIL reset: ack=%b valid=%b count=%0d data=%h required 0 0 0 0",
                 ack, out_valid, count, out_data);
      end
    end
    rst = 1'b0;
    send = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    data = 4'hA;
    send = 1'b1;
    exp_q.push_back(4'hA);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (ack !== 1'b0) begin
      fails++;
      $display("FAIL single_early: ack=%b required 0", ack);
    end
    @(negedge clk);
    tests++;
    if (ack !== 1'b1 || out_valid !== 1'b1 || out_data !== 4'hA
        || count !== 3'd1) begin
      fails++;
      $display("FAIL single_push: ack=%b valid=%b data=%h count=%0d required 1 1 a 1",
               ack, out_valid, out_data, count);
    end
    send = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL single_ack_hold: ack=%b required 1", ack);
    end
    @(negedge clk);
    tests++;
    if (ack !== 1'b0) begin
      fails++;
      $display("FAIL single_ack_fall: ack=%b required 0", ack);
    end
    pop_one("single_pop");
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) xfer(4'(i));
    tests++;
    if (count !== 3'd4) begin
      fails++;
      $display("FAIL full_count: count=%0d required 4", count);
    end
    data = 4'h5;
    send = 1'b1;
    exp_q.push_back(4'h5);
    repeat (6) @(negedge clk);
    tests++;
    if (ack !== 1'b0 || count !== 3'd4) begin
      fails++;
      $display("FAIL full_stall: ack=%b count=%0d required 0 4", ack, count);
    end
    pop_one("full_pop1");
    tests++;
    if (ack !== 1'b0 || count !== 3'd3) begin
      fails++;
      $display("FAIL full_after_pop: ack=%b count=%0d required 0 3", ack, count);
    end
    @(negedge clk);
    tests++;
    if (ack !== 1'b1 || count !== 3'd4) begin
      fails++;
      $display("FAIL full_retry: ack=%b count=%0d required 1 4", ack, count);
    end
    send = 1'b0;
    wait_ack(1'b0, "full_ack_lo");
    for (int i = 0; i < 4; i++) pop_one("full_drain");
    tests++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_empty: count=%0d valid=%b required 0 0", count, out_valid);
    end
  endtask

  task automatic test_simul();
    xfer(4'h6);
    xfer(4'h7);
    data = 4'h8;
    send = 1'b1;
    exp_q.push_back(4'h8);
    @(negedge clk);
    @(negedge clk);
    pop_one("simul_pop");
    tests++;
    if (count !== 3'd2 || ack !== 1'b1) begin
      fails++;
      $display("FAIL simul_count: count=%0d ack=%b required 2 1", count, ack);
    end
    send = 1'b0;
    wait_ack(1'b0, "simul_ack_lo");
    pop_one("simul_drain");
    pop_one("simul_drain");
  endtask

  task automatic test_reset_mid();
    data = 4'h9;
    send = 1'b1;
    wait_ack(1'b1, "mid_ack_hi");
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (ack !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: ack=%b count=%0d valid=%b required 0 0 0",
               ack, count, out_valid);
    end
    rst = 1'b0;
    exp_q.push_back(4'h9);
    wait_ack(1'b1, "mid_reaccept");
    tests++;
    if (count !== 3'd1) begin
      fails++;
      $display("FAIL mid_count: count=%0d required 1", count);
    end
    send = 1'b0;
    wait_ack(1'b0, "mid_ack_lo");
    pop_one("mid_pop");
  endtask

  task automatic sclk_sender();
    int n;
    for (int i = 0; i < 8; i++) begin
      @(posedge sclk);
      data = 4'($urandom_range(0, 15));
      send = 1'b1;
      exp_q.push_back(data);
      n = 0;
      while (ack !== 1'b1 && n < 100) begin
        @(posedge sclk);
        n++;
      end
      @(posedge sclk);
      send = 1'b0;
      n = 0;
      while (ack !== 1'b0 && n < 100) begin
        @(posedge sclk);
        n++;
      end
    end
  endtask

  task automatic test_clock_ratio();
    fork
      sclk_sender();
      for (int i = 0; i < 8; i++) pop_one("ratio_pop");
    join
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0 || count !== 3'd0) begin
      fails++;
      $display("FAIL ratio_leftover: queued=%0d count=%0d required 0 0",
               exp_q.size(), count);
    end
  endtask

  initial begin
    rst = 1'b1;
    send = 1'b0;
    data = 4'h0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_simul();
    test_reset_mid();
    test_clock_ratio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
